// File: rtl/fetch_unit_pkg.sv
// fetch_defs: shared definitions for the instruction fetch unit
// Provides the fetch FSM state encoding, privilege level constants,
// the JAL opcode and the J-type immediate extraction helper.
package fetch_defs;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DROP
    } fetch_state_t;

    localparam logic [1:0] PRIV_USER    = 2'b00;
    localparam logic [1:0] PRIV_SUPER   = 2'b01;
    localparam logic [1:0] PRIV_MACHINE = 2'b11;

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    // J-type immediate: imm[20|10:1|11|19:12] lives in inst[31|30:21|20|19:12]
    function automatic logic [31:0] j_imm(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_jal_predecode.sv
// fetch_jal_predecode: finds the first JAL in a fetched instruction pair
// Ports:
//   pair_i   [63:0]  instruction pair, [31:0] at the aligned address, [63:32] at +4
//   pc_i     [31:2]  word address of the first valid slot (bit 2 set => slot 0 skipped)
//   taken_o  [1:0]   one-hot slot holding the first JAL, 0 when none
//   target_o [31:0]  slot PC + J-immediate of that JAL (don't care when taken_o is 0)
module fetch_jal_predecode
    import fetch_defs::*;
(
    input  logic [63:0] pair_i,
    input  logic [31:2] pc_i,
    output logic [1:0]  taken_o,
    output logic [31:0] target_o
);

    logic [31:0] w_base;
    logic        w_jal0;
    logic        w_jal1;

    assign w_base  = {pc_i[31:3], 3'b000};
    assign w_jal0  = !pc_i[2] && (pair_i[6:0] == OPC_JAL);
    // slot 1 only wins when slot 0 is skipped or not a JAL
    assign w_jal1  = !w_jal0 && (pair_i[38:32] == OPC_JAL);
    assign taken_o = {w_jal1, w_jal0};
    assign target_o = w_jal0 ? w_base + j_imm(pair_i[31:0])
                             : w_base + 32'd4 + j_imm(pair_i[63:32]);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing 64-bit aligned pair reads and registering them for decode
// Optional feature: define FETCH_JAL_PREDICT_EN to pre-decode captured pairs and
// follow the first JAL in the pair instead of fetching sequentially.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   branch_request_i/pc_i/priv_i  back-end redirect (highest priority)
//   icache_rd_o/pc_o/priv_o       request to the instruction cache, held until accepted
//   icache_accept_i               cache took the request this cycle
//   icache_valid_i/inst_i         response and instruction pair
//   icache_error_i/page_fault_i   response fault flags
//   fetch_valid_o .. fault_page_o registered pair towards decode
//   fetch_accept_i                decode consumed the pair this cycle
module fetch_unit
    import fetch_defs::*;
#(
    parameter logic [31:0] BOOT_VECTOR = 32'h80000000,
    parameter logic [1:0]  BOOT_PRIV   = PRIV_MACHINE
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_request_i,
    input  logic [31:0] branch_pc_i,
    input  logic [1:0]  branch_priv_i,
    output logic        icache_rd_o,
    output logic [31:0] icache_pc_o,
    output logic [1:0]  icache_priv_o,
    input  logic        icache_accept_i,
    input  logic        icache_valid_i,
    input  logic [63:0] icache_inst_i,
    input  logic        icache_error_i,
    input  logic        icache_page_fault_i,
    output logic        fetch_valid_o,
    output logic [63:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    output logic [1:0]  fetch_pred_branch_o,
    output logic        fetch_fault_fetch_o,
    output logic        fetch_fault_page_o,
    input  logic        fetch_accept_i
);

    fetch_state_t r_state;
    logic         r_rd;
    logic [31:0]  r_pc;
    logic [1:0]   r_priv;
    logic         r_stall;
    logic         r_valid;
    logic [63:0]  r_instr;
    logic [31:0]  r_fpc;
    logic [1:0]   r_pred;
    logic         r_ff;
    logic         r_fp;

    logic         w_fault;
    logic         w_out_free;
    logic [1:0]   w_taken;
    logic [31:0]  w_target;
    logic [31:0]  w_seq;
    logic [31:0]  w_next;

    assign w_fault    = icache_error_i | icache_page_fault_i;
    assign w_out_free = !r_valid || fetch_accept_i;
    assign w_seq      = {r_pc[31:3] + 29'd1, 3'b000};

`ifdef FETCH_JAL_PREDICT_EN
    fetch_jal_predecode u_predecode (
        .pair_i   (icache_inst_i),
        .pc_i     (r_pc[31:2]),
        .taken_o  (w_taken),
        .target_o (w_target)
    );
`else
    assign w_taken  = 2'b00;
    assign w_target = w_seq;
`endif

    assign w_next = (!w_fault && |w_taken) ? w_target : w_seq;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_rd    <= 1'b0;
            r_pc    <= BOOT_VECTOR;
            r_priv  <= BOOT_PRIV;
            r_stall <= 1'b0;
            r_valid <= 1'b0;
            r_instr <= '0;
            r_fpc   <= '0;
            r_pred  <= 2'b00;
            r_ff    <= 1'b0;
            r_fp    <= 1'b0;
        end else if (branch_request_i) begin
            r_pc    <= branch_pc_i & ~32'd3;
            r_priv  <= branch_priv_i;
            r_stall <= 1'b0;
            r_valid <= 1'b0;
            r_rd    <= 1'b0;
            // a response landing in this cycle is simply discarded and closes the
            // outstanding request, so only a still-pending request needs DROP
            r_state <= (((r_state == ST_WAIT) || (r_state == ST_DROP)) && !icache_valid_i) ||
                       ((r_state == ST_REQ) && icache_accept_i) ? ST_DROP : ST_IDLE;
        end else begin
            if (fetch_accept_i)
                r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_stall && w_out_free) begin
                        r_state <= ST_REQ;
                        r_rd    <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (icache_accept_i) begin
                        r_state <= ST_WAIT;
                        r_rd    <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (icache_valid_i) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b1;
                        r_fpc   <= r_pc;
                        r_instr <= w_fault ? '0 : icache_inst_i;
                        r_pred  <= w_fault ? 2'b00 : w_taken;
                        r_ff    <= icache_error_i;
                        r_fp    <= icache_page_fault_i;
                        r_stall <= w_fault;
                        r_pc    <= w_next;
                    end
                end
                ST_DROP: begin
                    if (icache_valid_i)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign icache_rd_o         = r_rd;
    assign icache_pc_o         = {r_pc[31:3], 3'b000};
    assign icache_priv_o       = r_priv;
    assign fetch_valid_o       = r_valid;
    assign fetch_instr_o       = r_instr;
    assign fetch_pc_o          = r_fpc;
    assign fetch_pred_branch_o = r_pred;
    assign fetch_fault_fetch_o = r_ff;
    assign fetch_fault_page_o  = r_fp;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit against a transaction-level model
module tb_fetch_unit;

`ifdef FETCH_JAL_PREDICT_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif
    localparam logic [31:0] BOOT = 32'h80000000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        branch_request_i;
    logic [31:0] branch_pc_i;
    logic [1:0]  branch_priv_i;
    logic        icache_rd_o;
    logic [31:0] icache_pc_o;
    logic [1:0]  icache_priv_o;
    logic        icache_accept_i;
    logic        icache_valid_i;
    logic [63:0] icache_inst_i;
    logic        icache_error_i;
    logic        icache_page_fault_i;
    logic        fetch_valid_o;
    logic [63:0] fetch_instr_o;
    logic [31:0] fetch_pc_o;
    logic [1:0]  fetch_pred_branch_o;
    logic        fetch_fault_fetch_o;
    logic        fetch_fault_page_o;
    logic        fetch_accept_i;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .branch_request_i    (branch_request_i),
        .branch_pc_i         (branch_pc_i),
        .branch_priv_i       (branch_priv_i),
        .icache_rd_o         (icache_rd_o),
        .icache_pc_o         (icache_pc_o),
        .icache_priv_o       (icache_priv_o),
        .icache_accept_i     (icache_accept_i),
        .icache_valid_i      (icache_valid_i),
        .icache_inst_i       (icache_inst_i),
        .icache_error_i      (icache_error_i),
        .icache_page_fault_i (icache_page_fault_i),
        .fetch_valid_o       (fetch_valid_o),
        .fetch_instr_o       (fetch_instr_o),
        .fetch_pc_o          (fetch_pc_o),
        .fetch_pred_branch_o (fetch_pred_branch_o),
        .fetch_fault_fetch_o (fetch_fault_fetch_o),
        .fetch_fault_page_o  (fetch_fault_page_o),
        .fetch_accept_i      (fetch_accept_i)
    );

    int checks = 0;
    int failures = 0;

    // stimulus knobs (percent probabilities and response delay window)
    int          p_acc = 100, p_fa = 100, p_br = 0, p_err = 0, p_pf = 0;
    int          min_dly = 0, max_dly = 0;
    logic        f_br = 1'b0, f_pf = 1'b0, stale = 1'b0, use_fix = 1'b0;
    logic [31:0] f_bpc = '0;
    logic [1:0]  f_bpriv = 2'b11;
    logic [63:0] fix_data = '0;

    // reference model state
    logic [31:0] fpc;
    logic [1:0]  e_priv;
    logic        stalled, pend, pend_kill;
    int          pend_cnt;
    logic [31:0] pend_pc;
    logic        e_valid, e_ff, e_fp;
    logic [63:0] e_instr;
    logic [31:0] e_pc;
    logic [1:0]  e_pred;
    int          pairs = 0;
    logic [31:0] acc_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] pred_of(input logic [63:0] d, input logic [31:0] pc);
        if (!JAL_EN)
            return 2'b00;
        for (int s = int'(pc[2]); s < 2; s++)
            if (d[32*s +: 7] == 7'b1101111)
                return (s == 0) ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] next_of(input logic [63:0] d, input logic [31:0] pc);
        logic [1:0]  p;
        logic [31:0] w;
        logic [31:0] slot_pc;
        p = pred_of(d, pc);
        if (p == 2'b00)
            return (pc & ~32'd7) + 32'd8;
        w = p[1] ? d[63:32] : d[31:0];
        slot_pc = (pc & ~32'd7) + (p[1] ? 32'd4 : 32'd0);
        return slot_pc + {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    task automatic do_reset(input int n);
        rst_i = 1'b1;
        branch_request_i = 1'b0;
        icache_accept_i = 1'b0;
        icache_valid_i = 1'b1;
        icache_inst_i = {$urandom, $urandom};
        icache_error_i = 1'b0;
        icache_page_fault_i = 1'b0;
        fetch_accept_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        check("rst_valid", fetch_valid_o, 0);
        check("rst_instr", fetch_instr_o, 0);
        check("rst_pc", fetch_pc_o, 0);
        check("rst_pred", fetch_pred_branch_o, 0);
        check("rst_faults", {fetch_fault_fetch_o, fetch_fault_page_o}, 0);
        check("rst_rd", icache_rd_o, 0);
        check("rst_ipc", icache_pc_o, BOOT);
        check("rst_priv", icache_priv_o, 2'b11);
        rst_i = 1'b0;
        fpc = BOOT;
        e_priv = 2'b11;
        stalled = 1'b0;
        pend = 1'b0;
        pend_kill = 1'b0;
        e_valid = 1'b0;
    endtask

    // one clock: check outputs, pick inputs, advance the model, move to next cycle
    task automatic step();
        logic        acc, rsp, br, fa, er, pf, kill;
        logic [63:0] d;
        logic [31:0] bpc, rpc;
        logic [1:0]  bpv;
        check("valid", fetch_valid_o, e_valid);
        if (e_valid) begin
            check("pc", fetch_pc_o, e_pc);
            check("instr", fetch_instr_o, e_instr);
            check("pred", fetch_pred_branch_o, e_pred);
            check("faults", {fetch_fault_fetch_o, fetch_fault_page_o}, {e_ff, e_fp});
        end
        fa = $urandom_range(99) < p_fa;
        if (icache_rd_o) begin
            check("req_addr", icache_pc_o, fpc & ~32'd7);
            check("req_priv", icache_priv_o, e_priv);
            check("req_legal", stalled || pend || (e_valid && !fa), 0);
        end
        acc = icache_rd_o && !pend && ($urandom_range(99) < p_acc);
        rsp = pend && (pend_cnt == 0);
        d = {$urandom, $urandom};
        if ($urandom_range(3) == 0) d[6:0] = 7'b1101111;
        if ($urandom_range(3) == 0) d[38:32] = 7'b1101111;
        if (use_fix) d = fix_data;
        er = rsp && ($urandom_range(99) < p_err);
        pf = rsp && (f_pf || ($urandom_range(99) < p_pf));
        br = f_br || ($urandom_range(99) < p_br);
        bpc = f_br ? f_bpc : $urandom;
        bpv = f_br ? f_bpriv : 2'($urandom);
        icache_accept_i = acc;
        icache_valid_i = rsp || stale;
        icache_inst_i = d;
        icache_error_i = er;
        icache_page_fault_i = pf;
        branch_request_i = br;
        branch_pc_i = bpc;
        branch_priv_i = bpv;
        fetch_accept_i = fa;
        kill = pend_kill;
        rpc = pend_pc;
        if (rsp) pend = 1'b0;
        else if (pend) pend_cnt--;
        if (br) begin
            e_valid = 1'b0;
        end else if (rsp && !kill) begin
            e_valid = 1'b1;
            e_pc = rpc;
            e_ff = er;
            e_fp = pf;
            e_instr = (er || pf) ? 64'd0 : d;
            e_pred = (er || pf) ? 2'b00 : pred_of(d, rpc);
            stalled = er || pf;
            if (!(er || pf)) fpc = next_of(d, rpc);
            pairs++;
        end else if (fa) begin
            e_valid = 1'b0;
        end
        if (acc) begin
            acc_q.push_back(icache_pc_o);
            pend = 1'b1;
            pend_kill = 1'b0;
            pend_pc = fpc;
            pend_cnt = $urandom_range(max_dly, min_dly);
        end
        if (br) begin
            if (pend) pend_kill = 1'b1;
            fpc = bpc & ~32'd3;
            e_priv = bpv;
            stalled = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int n, input string tag);
        int t = 0;
        while (acc_q.size() < n && t < 80) begin
            step();
            t++;
        end
        check({tag, "_reached"}, 64'(acc_q.size() >= n), 1);
    endtask

    task automatic redirect(input logic [31:0] pc);
        f_br = 1'b1;
        f_bpc = pc;
        f_bpriv = 2'b11;
        step();
        f_br = 1'b0;
    endtask

    initial begin
        int n, t;
        rst_i = 1'b1;
        branch_pc_i = '0;
        branch_priv_i = 2'b00;
        do_reset(3);

        // first fetch after reset, with a stale response during and right after reset
        use_fix = 1'b1;
        fix_data = 64'h00A00513_00000013;
        stale = 1'b1;
        step();
        stale = 1'b0;
        wait_acc(2, "t1");
        check("t1_first_req", acc_q[0], 32'h80000000);
        check("t1_second_req", acc_q[1], 32'h80000008);

        // decode back-pressure: no requests while the pair is held
        p_fa = 0;
        t = 0;
        while (!e_valid && t < 40) begin step(); t++; end
        check("t2_have_pair", fetch_valid_o, 1);
        for (int i = 0; i < 3; i++) begin
            check("t2_hold_rd", icache_rd_o, 0);
            step();
        end
        p_fa = 100;
        n = acc_q.size();
        wait_acc(n + 1, "t2");

        // redirect while a response is outstanding
        min_dly = 3;
        max_dly = 3;
        t = 0;
        while (!pend && t < 40) begin step(); t++; end
        redirect(32'h00002004);
        min_dly = 0;
        max_dly = 0;
        n = acc_q.size();
        wait_acc(n + 2, "t3");
        check("t3_req_2000", acc_q[n], 32'h00002000);
        check("t3_req_2008", acc_q[n+1], 32'h00002008);

        // page fault stalls fetch until a redirect
        f_pf = 1'b1;
        t = 0;
        while (!stalled && t < 40) begin step(); t++; end
        f_pf = 1'b0;
        n = acc_q.size();
        repeat (5) step();
        check("t4_no_req", acc_q.size(), n);
        redirect(32'h00003000);
        wait_acc(n + 1, "t4");
        check("t4_req_3000", acc_q[n], 32'h00003000);

        // sequential wrap at the top of the address space
        redirect(32'hFFFFFFF8);
        n = acc_q.size();
        wait_acc(n + 2, "t5");
        check("t5_req_top", acc_q[n], 32'hFFFFFFF8);
        check("t5_req_wrap", acc_q[n+1], 32'h00000000);

        // JAL +0x100 in slot 0
        fix_data = 64'h00000013_1000006F;
        redirect(32'h00001000);
        n = acc_q.size();
        wait_acc(n + 2, "t6");
        check("t6_req_1000", acc_q[n], 32'h00001000);
        check("t6_req_next", acc_q[n+1], JAL_EN ? 32'h00001100 : 32'h00001008);
        use_fix = 1'b0;

        // reset while a request is outstanding
        min_dly = 2;
        max_dly = 2;
        t = 0;
        while (!pend && t < 40) begin step(); t++; end
        do_reset(2);
        stale = 1'b1;
        step();
        stale = 1'b0;

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                p_acc = $urandom_range(100, 30);
                p_fa = $urandom_range(100, 20);
                p_br = $urandom_range(10, 1);
                p_err = $urandom_range(5, 0);
                p_pf = $urandom_range(5, 0);
                min_dly = 0;
                max_dly = $urandom_range(3, 0);
            end
            step();
        end
        check("liveness", 64'(pairs > 100), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
